// File: rtl/bt_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bt_tx_arbiter
// Purpose  : Shares one UART transmitter between two byte-stream requesters.
//            Arbitration is round-robin per packet. The winner keeps the grant
//            until its "last" byte has fully shifted out, or until a
//            mid-packet stall exceeds TIMEOUT cycles (packet aborted). A fixed
//            idle gap of GAP_CYCLES separates consecutive packets.
// Ports    :
//   clk, rst                  clock / asynchronous active-high reset
//   req0_valid/data/last      requester 0 byte stream (valid/ready handshake)
//   req0_ready                requester 0 byte accepted when valid && ready
//   req1_valid/data/last      requester 1 byte stream
//   req1_ready                requester 1 byte accepted when valid && ready
//   tx_start                  one-cycle load pulse to the UART core
//   tx_data                   byte for the UART, held from start until done
//   tx_busy                   UART core is shifting
//   grant                     one-hot owner, 2'b00 when nobody owns the line
//   abort                     one-cycle pulse when a stalled packet is dropped
// Revision : 1.0 - initial release
// ============================================================================
module bt_tx_arbiter #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic [1:0]        grant,
  output logic              abort
);

  // Counter widths: each counter only needs to reach its terminal value.
  localparam int                 STALL_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int                 GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  // Registered state
  state_t             state;
  logic               ptr;        // requester preferred on a tie
  logic               last_r;     // byte in flight closes the packet
  logic [STALL_W-1:0] stall_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  // Next-state values
  state_t             state_nxt;
  logic               ptr_nxt;
  logic               last_nxt;
  logic [STALL_W-1:0] stall_nxt;
  logic [GAP_W-1:0]   gap_nxt;
  logic [1:0]         grant_nxt;
  logic               start_nxt;
  logic               abort_nxt;
  logic [DATA_W-1:0]  data_nxt;
  logic               pick1;

  // Granted requester's stream, selected by the current owner
  logic               sel_valid;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_last;

  // Readies depend only on registered state so a requester can never see a
  // combinational loop through its own valid.
  assign req0_ready = (state == ST_LOAD) && grant[0];
  assign req1_ready = (state == ST_LOAD) && grant[1];

  assign sel_valid  = grant[1] ? req1_valid : req0_valid;
  assign sel_data   = grant[1] ? req1_data  : req0_data;
  assign sel_last   = grant[1] ? req1_last  : req0_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= 1'b0;
      last_r    <= 1'b0;
      stall_cnt <= '0;
      gap_cnt   <= '0;
      grant     <= 2'b00;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      abort     <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      last_r    <= last_nxt;
      stall_cnt <= stall_nxt;
      gap_cnt   <= gap_nxt;
      grant     <= grant_nxt;
      tx_start  <= start_nxt;
      tx_data   <= data_nxt;
      abort     <= abort_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    last_nxt  = last_r;
    stall_nxt = stall_cnt;
    gap_nxt   = gap_cnt;
    grant_nxt = grant;
    start_nxt = 1'b0;
    abort_nxt = 1'b0;
    data_nxt  = tx_data;
    pick1     = 1'b0;

    case (state)
      ST_IDLE: begin
        // Never start a packet while the UART is still finishing something.
        if (!tx_busy && (req0_valid || req1_valid)) begin
          if (req0_valid && req1_valid) begin
            pick1 = ptr;
          end else begin
            pick1 = req1_valid;
          end
          grant_nxt = pick1 ? 2'b10 : 2'b01;
          ptr_nxt   = ~pick1;
          stall_nxt = '0;
          state_nxt = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // Ready is high for the owner here, so owner valid means handshake.
        if (sel_valid) begin
          data_nxt  = sel_data;
          last_nxt  = sel_last;
          start_nxt = 1'b1;
          stall_nxt = '0;
          state_nxt = ST_WAIT_BUSY;
        end else if (stall_cnt == STALL_LAST) begin
          abort_nxt = 1'b1;
          grant_nxt = 2'b00;
          stall_nxt = '0;
          gap_nxt   = '0;
          state_nxt = ST_GAP;
        end else begin
          stall_nxt = stall_cnt + 1'b1;
        end
      end

      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_r) begin
            grant_nxt = 2'b00;
            gap_nxt   = '0;
            state_nxt = ST_GAP;
          end else begin
            state_nxt = ST_LOAD;
          end
        end
      end

      ST_GAP: begin
        grant_nxt = 2'b00;
        if (gap_cnt == GAP_LAST) begin
          gap_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end

      default: begin
        grant_nxt = 2'b00;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
